// File: rtl/pc_stack.sv
// Program counter with increment, absolute load, relative branch and a
// hardware return-address stack for CALL/RET.
module pc_stack #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned RESET_ADDR  = 0,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PC_EN,
    input  logic              LOAD_EN,
    input  logic              BR_EN,
    input  logic              CALL_EN,
    input  logic              RET_EN,
    input  logic [ADDR_W-1:0] I_ADDR,
    input  logic [ADDR_W-1:0] I_OFFSET,
    output logic [ADDR_W-1:0] O_ADDR,
    output logic              STK_EMPTY,
    output logic              STK_FULL,
    output logic              STK_ERR
);

    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
    // Storage is sized to the full index range so count_q indexes it without truncation.
    localparam int unsigned STACK_SLOTS = 1 << CNT_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  top_idx;
    logic              err_q, err_d;
    logic              push;
    logic [ADDR_W-1:0] stack_q [STACK_SLOTS];

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign top_idx = count_q - CNT_W'(1);

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        err_d   = err_q;
        push    = 1'b0;
        if (PC_EN) begin
            if (RET_EN) begin
                if (count_q != '0) begin
                    pc_d    = stack_q[top_idx];
                    count_d = top_idx;
                end else begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end
            end else if (CALL_EN) begin
                // The jump is taken even when the push is dropped on overflow.
                pc_d = I_ADDR;
                if (count_q < DEPTH_C) begin
                    push    = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else if (LOAD_EN) begin
                pc_d = I_ADDR;
            end else if (BR_EN) begin
                pc_d = pc_q + I_OFFSET;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q    <= ADDR_W'(RESET_ADDR);
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            stack_q[count_q] <= pc_inc;
        end
    end

    assign O_ADDR    = pc_q;
    assign STK_EMPTY = (count_q == '0);
    assign STK_FULL  = (count_q == DEPTH_C);
    assign STK_ERR   = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: stimulus pushes expected post-edge state into a
// queue, a monitor pops and compares one entry after every rising edge.
module tb_pc_stack;

    localparam int unsigned AW = 5;

    // ctrl = {rst, pc_en, ret, call, load, br}
    localparam logic [5:0] C_R   = 6'b100000;
    localparam logic [5:0] C_P   = 6'b010000;
    localparam logic [5:0] C_RET = 6'b011000;
    localparam logic [5:0] C_CAL = 6'b010100;
    localparam logic [5:0] C_LD  = 6'b010010;
    localparam logic [5:0] C_BR  = 6'b010001;

    logic          clk = 1'b0;
    logic          rst, pc_en, load_en, br_en, call_en, ret_en;
    logic [AW-1:0] i_addr, i_offset, o_addr;
    logic          stk_empty, stk_full, stk_err;

    logic [7:0]    exp_q [$];
    string         name_q [$];
    int            passed = 0;
    int            total  = 0;

    always #5 clk = ~clk;

    pc_stack #(
        .ADDR_W      (AW),
        .RESET_ADDR  (3),
        .STACK_DEPTH (4)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .PC_EN     (pc_en),
        .LOAD_EN   (load_en),
        .BR_EN     (br_en),
        .CALL_EN   (call_en),
        .RET_EN    (ret_en),
        .I_ADDR    (i_addr),
        .I_OFFSET  (i_offset),
        .O_ADDR    (o_addr),
        .STK_EMPTY (stk_empty),
        .STK_FULL  (stk_full),
        .STK_ERR   (stk_err)
    );

    // flags = {empty, full, err}
    task automatic step(input string nm, input logic [5:0] c, input logic [AW-1:0] a,
                        input logic [AW-1:0] o, input logic [AW-1:0] ea,
                        input logic [2:0] flags);
        {rst, pc_en, ret_en, call_en, load_en, br_en} = c;
        i_addr   = a;
        i_offset = o;
        exp_q.push_back({ea, flags});
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a new state after every rising edge.
    initial begin
        logic [7:0] e, g;
        string      n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                g = {o_addr, stk_empty, stk_full, stk_err};
                total++;
                if (g === e) passed++;
                else $display("FAIL %s: got addr=%0d efe=%b, expected addr=%0d efe=%b",
                              n, g[7:3], g[2:0], e[7:3], e[2:0]);
            end
        end
    end

    initial begin
        {rst, pc_en, ret_en, call_en, load_en, br_en} = '0;
        i_addr   = '0;
        i_offset = '0;

        step("reset", C_R, 0, 0, 3, 3'b100);
        for (int i = 1; i <= 31; i++) begin
            step("incr", C_P, 0, 0, AW'((3 + i) % 32), 3'b100);
        end

        // Hold / load / branch
        step("load10", C_LD, 10, 0, 10, 3'b100);
        step("hold1", 6'b001111, 1, 1, 10, 3'b100);
        step("hold2", 6'b001111, 2, 2, 10, 3'b100);
        step("hold3", 6'b001111, 3, 3, 10, 3'b100);
        step("load20", C_LD, 20, 0, 20, 3'b100);
        step("br_m3", C_BR, 0, 5'b11101, 17, 3'b100);
        step("br_p20", C_BR, 0, 20, 5, 3'b100);
        step("br_0", C_BR, 0, 0, 5, 3'b100);

        // Nested call / return
        step("load6", C_LD, 6, 0, 6, 3'b100);
        step("call12", C_CAL, 12, 0, 12, 3'b000);
        step("call25", C_CAL, 25, 0, 25, 3'b000);
        step("ret13", C_RET, 0, 0, 13, 3'b000);
        step("ret7", C_RET, 0, 0, 7, 3'b100);

        // Overflow
        step("ovf_c1", C_CAL, 10, 0, 10, 3'b000);
        step("ovf_c2", C_CAL, 15, 0, 15, 3'b000);
        step("ovf_c3", C_CAL, 20, 0, 20, 3'b000);
        step("ovf_c4", C_CAL, 28, 0, 28, 3'b010);
        step("ovf_c5", C_CAL, 9, 0, 9, 3'b011);
        step("ovf_r1", C_RET, 0, 0, 21, 3'b001);
        step("ovf_r2", C_RET, 0, 0, 16, 3'b001);
        step("ovf_r3", C_RET, 0, 0, 11, 3'b001);
        step("ovf_r4", C_RET, 0, 0, 8, 3'b101);

        // Underflow and priority
        step("reset2", C_R, 0, 0, 3, 3'b100);
        step("ld_over_br", C_LD | C_BR, 31, 1, 31, 3'b100);
        step("unf_ret", C_RET, 0, 0, 0, 3'b101);
        step("load7", C_LD, 7, 0, 7, 3'b101);
        step("call20", C_CAL, 20, 0, 20, 3'b001);
        step("ret_prio", C_RET | C_CAL | C_LD, 30, 0, 8, 3'b101);
        step("ret_nopush", C_RET, 0, 0, 9, 3'b101);
        step("hold_all", 6'b001111, 30, 7, 9, 3'b101);
        step("call_prio", C_CAL | C_LD | C_BR, 14, 3, 14, 3'b001);
        step("ret10", C_RET, 0, 0, 10, 3'b101);

        // Reset mid-operation
        step("reset3", C_R, 0, 0, 3, 3'b100);
        step("mid_c1", C_CAL, 12, 0, 12, 3'b000);
        step("mid_c2", C_CAL, 18, 0, 18, 3'b000);
        step("rst_call", C_R | C_CAL, 5, 0, 3, 3'b100);
        step("post_unf", C_RET, 0, 0, 4, 3'b101);
        step("rst_all", 6'b111111, 1, 1, 3, 3'b100);
        step("incr_end", C_P, 0, 0, 4, 3'b100);

        {rst, pc_en, ret_en, call_en, load_en, br_en} = '0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
